// File: rtl/pair_check_sequencer_if.sv
// rtl/pair_check_sequencer_if.sv - start/operand/check-stream bundle for pair_check_sequencer
interface pair_check_sequencer_if #(
  parameter int WIDTH = 11,
  parameter int COUNT = 10
);
  logic                         start;
  logic [WIDTH-1:0]             foo;
  logic [WIDTH-1:0]             bar;
  logic                         busy;
  logic                         chk_valid;
  logic [$clog2(WIDTH)-1:0]     chk_idx;
  logic                         chk_ok;
  logic                         done;
  logic                         any_fail;
  logic [$clog2(COUNT+1)-1:0]   fail_cnt;
  logic [$clog2(WIDTH)-1:0]     first_fail_idx;

  modport master (
    output start, foo, bar,
    input  busy, chk_valid, chk_idx, chk_ok, done, any_fail, fail_cnt, first_fail_idx
  );

  modport slave (
    input  start, foo, bar,
    output busy, chk_valid, chk_idx, chk_ok, done, any_fail, fail_cnt, first_fail_idx
  );
endinterface

// File: rtl/pair_check_sequencer.sv
// rtl/pair_check_sequencer.sv - snapshot foo/bar, check foo[i]&bar[i] for i=0..COUNT-1, one per clock
// Optional PAIR_CHECK_STOP_ON_FAIL_EN ends the scan at the first failing index.
module pair_check_sequencer #(
  parameter int WIDTH = 11,
  parameter int COUNT = 10
) (
  input logic                   i_clk,
  input logic                   i_rst,
  pair_check_sequencer_if.slave bus
);
  localparam int IDXW = $clog2(WIDTH);
  localparam int CNTW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_snap_foo;
  logic [WIDTH-1:0] r_snap_bar;
  logic [IDXW-1:0]  r_idx;
  logic [IDXW-1:0]  r_first_fail_idx;
  logic [CNTW-1:0]  r_fail_cnt;
  logic             r_any_fail;
  logic             r_busy;
  logic             r_chk_valid;
  logic             r_done;

  logic w_bit_ok;
  logic w_last;
  logic w_end_scan;

  assign w_bit_ok = r_snap_foo[r_idx] & r_snap_bar[r_idx];
  assign w_last   = (r_idx == IDXW'(COUNT - 1));

`ifdef PAIR_CHECK_STOP_ON_FAIL_EN
  assign w_end_scan = w_last | ~w_bit_ok;
`else
  assign w_end_scan = w_last;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_snap_foo       <= '0;
      r_snap_bar       <= '0;
      r_idx            <= '0;
      r_first_fail_idx <= '0;
      r_fail_cnt       <= '0;
      r_any_fail       <= 1'b0;
      r_busy           <= 1'b0;
      r_chk_valid      <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_snap_foo       <= bus.foo;
            r_snap_bar       <= bus.bar;
            r_idx            <= '0;
            r_first_fail_idx <= '0;
            r_fail_cnt       <= '0;
            r_any_fail       <= 1'b0;
            r_busy           <= 1'b1;
            r_chk_valid      <= 1'b1;
            r_state          <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_bit_ok) begin
            r_fail_cnt <= r_fail_cnt + CNTW'(1);
            if (!r_any_fail) r_first_fail_idx <= r_idx;
            r_any_fail <= 1'b1;
          end
          if (w_end_scan) begin
            r_chk_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          // Results stay registered here until the next accepted start.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.chk_valid      = r_chk_valid;
  assign bus.chk_idx        = r_idx;
  assign bus.chk_ok         = r_chk_valid & w_bit_ok;
  assign bus.done           = r_done;
  assign bus.any_fail       = r_any_fail;
  assign bus.fail_cnt       = r_fail_cnt;
  assign bus.first_fail_idx = r_first_fail_idx;
endmodule

// File: tb/tb_pair_check_sequencer.sv
// tb/tb_pair_check_sequencer.sv - randomized and directed checks of pair_check_sequencer against a scan model
module tb_pair_check_sequencer;
  localparam int WIDTH = 11;
  localparam int COUNT = 10;
`ifdef PAIR_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pair_check_sequencer_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();
  pair_check_sequencer #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int exp_n, exp_cnt, exp_first;
  bit exp_any;

  int obs_idx[$];
  bit obs_ok[$];
  int obs_lat, obs_cnt, obs_first;
  bit obs_timeout, obs_any, obs_done_after, obs_busy_after;

  task automatic model(input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] b);
    exp_cnt = 0; exp_any = 0; exp_first = 0; exp_n = COUNT;
    for (int i = 0; i < COUNT; i++) begin
      if (!(f[i] && b[i])) begin
        if (!exp_any) exp_first = i;
        exp_any = 1;
        exp_cnt++;
        if (STOP) begin
          exp_n = i + 1;
          break;
        end
      end
    end
  endtask

  task automatic run_scan(input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] b, input bit clobber);
    obs_idx.delete(); obs_ok.delete();
    obs_timeout = 1; obs_lat = 0; obs_cnt = -1; obs_first = -1; obs_any = 0;
    bus.foo = f; bus.bar = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (clobber) bus.bar = '0;
    for (int c = 0; c < COUNT + 5; c++) begin
      if (bus.chk_valid) begin
        obs_idx.push_back(int'(bus.chk_idx));
        obs_ok.push_back(bus.chk_ok);
      end
      if (bus.done) begin
        obs_timeout = 0;
        obs_lat     = c + 1;
        obs_cnt     = int'(bus.fail_cnt);
        obs_any     = bus.any_fail;
        obs_first   = int'(bus.first_fail_idx);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    obs_done_after = bus.done;
    obs_busy_after = bus.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.busy, bus.chk_valid, bus.chk_ok, bus.done, bus.any_fail} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 00000", {bus.busy, bus.chk_valid, bus.chk_ok, bus.done, bus.any_fail});
    end
    n_vec++;
    if ({bus.fail_cnt, bus.first_fail_idx, bus.chk_idx} !== '0) begin
      n_err++; $display("FAIL reset_values got cnt=%0d first=%0d idx=%0d want 0", bus.fail_cnt, bus.first_fail_idx, bus.chk_idx);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_scan_patterns(input string name, input int iters, input bit directed);
    logic [WIDTH-1:0] f, b;
    for (int t = 0; t < iters; t++) begin
      if (directed) begin
        case (t)
          0: begin f = 11'h7FF; b = 11'h7FF; end
          1: begin f = 11'h7FF; b = 11'h777; end
          default: begin f = 11'h3FF; b = 11'h7FF; end
        endcase
      end else begin
        case (t % 3)
          0: begin f = ~WIDTH'($urandom & $urandom & $urandom); b = ~WIDTH'($urandom & $urandom & $urandom); end
          1: begin f = WIDTH'($urandom); b = WIDTH'($urandom); end
          default: begin f = 11'h7FF; b = ~(WIDTH'(1) << $urandom_range(WIDTH - 1)); end
        endcase
      end
      model(f, b);
      run_scan(f, b, 1'b0);
      n_vec++;
      if (obs_timeout !== 1'b0) begin
        n_err++; $display("FAIL %s_done_seen t=%0d got timeout want done", name, t);
      end
      n_vec++;
      if (obs_lat != exp_n + 1) begin
        n_err++; $display("FAIL %s_latency t=%0d got %0d want %0d", name, t, obs_lat, exp_n + 1);
      end
      n_vec++;
      if (obs_idx.size() != exp_n) begin
        n_err++; $display("FAIL %s_chk_count t=%0d got %0d want %0d", name, t, obs_idx.size(), exp_n);
      end
      for (int i = 0; i < obs_idx.size() && i < exp_n; i++) begin
        n_vec++;
        if (obs_idx[i] != i || obs_ok[i] !== (f[i] & b[i])) begin
          n_err++; $display("FAIL %s_chk t=%0d i=%0d got idx=%0d ok=%0b want idx=%0d ok=%0b", name, t, i, obs_idx[i], obs_ok[i], i, f[i] & b[i]);
        end
      end
      n_vec++;
      if (obs_cnt != exp_cnt || obs_any !== exp_any || obs_first != exp_first) begin
        n_err++; $display("FAIL %s_results t=%0d f=%h b=%h got cnt=%0d any=%0b first=%0d want cnt=%0d any=%0b first=%0d",
                          name, t, f, b, obs_cnt, obs_any, obs_first, exp_cnt, exp_any, exp_first);
      end
      n_vec++;
      if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
        n_err++; $display("FAIL %s_idle_after t=%0d got done=%0b busy=%0b want 0 0", name, t, obs_done_after, obs_busy_after);
      end
    end
  endtask

  task automatic test_capture_isolation();
    run_scan(11'h7FF, 11'h7FF, 1'b1);
    n_vec++;
    if (obs_timeout !== 1'b0 || obs_cnt != 0 || obs_any !== 1'b0) begin
      n_err++; $display("FAIL capture_isolation got timeout=%0b cnt=%0d any=%0b want 0 0 0", obs_timeout, obs_cnt, obs_any);
    end
    n_vec++;
    if (obs_ok.size() != COUNT || (obs_ok.sum() with (int'(item))) != COUNT) begin
      n_err++; $display("FAIL capture_chk_ok got size=%0d want %0d all ok", obs_ok.size(), COUNT);
    end
  endtask

  task automatic test_back_to_back();
    int done_q[$];
    int valid_cnt = 0;
    int done_cnt = 0;
    bus.foo = 11'h7FF; bus.bar = 11'h7FF; bus.start = 1'b1;
    for (int c = 0; c < 3 * (COUNT + 2); c++) begin
      @(posedge clk); #1;
      if (bus.done) done_q.push_back(c);
      if (bus.chk_valid) valid_cnt++;
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (done_q.size() != 3 || valid_cnt != 3 * COUNT) begin
      n_err++; $display("FAIL b2b_counts got dones=%0d valids=%0d want 3 %0d", done_q.size(), valid_cnt, 3 * COUNT);
    end
    n_vec++;
    if (done_q.size() == 3 && (done_q[0] != COUNT || done_q[1] - done_q[0] != COUNT + 2 || done_q[2] - done_q[1] != COUNT + 2)) begin
      n_err++; $display("FAIL b2b_period got %0d,%0d,%0d want %0d,%0d,%0d", done_q[0], done_q[1], done_q[2], COUNT, 2 * COUNT + 2, 3 * COUNT + 4);
    end
    valid_cnt = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3 * COUNT; c++) begin
      bus.start = (c == 3 || c == COUNT - 1 || c == COUNT);
      if (bus.chk_valid) valid_cnt++;
      if (bus.done) done_cnt++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (valid_cnt != COUNT || done_cnt != 1) begin
      n_err++; $display("FAIL start_ignored got valids=%0d dones=%0d want %0d 1", valid_cnt, done_cnt, COUNT);
    end
  endtask

  task automatic test_mid_scan_reset();
    int done_cnt = 0;
    bus.foo = 11'h7FF; bus.bar = 11'h7FF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (bus.chk_valid !== 1'b1 || bus.chk_idx !== 4'd4) begin
      n_err++; $display("FAIL pre_reset got valid=%0b idx=%0d want 1 4", bus.chk_valid, bus.chk_idx);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus.busy, bus.chk_valid, bus.chk_ok, bus.done, bus.any_fail} !== 5'b0 ||
        {bus.fail_cnt, bus.first_fail_idx, bus.chk_idx} !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs got busy=%0b valid=%0b done=%0b cnt=%0d idx=%0d want all 0",
                        bus.busy, bus.chk_valid, bus.done, bus.fail_cnt, bus.chk_idx);
    end
    rst = 1'b0;
    for (int c = 0; c < COUNT + 4; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_cnt++;
    end
    n_vec++;
    if (done_cnt != 0) begin
      n_err++; $display("FAIL aborted_scan_activity got %0d active cycles want 0", done_cnt);
    end
    model(11'h7FF, 11'h7FE);
    run_scan(11'h7FF, 11'h7FE, 1'b0);
    n_vec++;
    if (obs_timeout !== 1'b0 || obs_cnt != exp_cnt || obs_first != exp_first || obs_any !== exp_any) begin
      n_err++; $display("FAIL post_reset_scan got cnt=%0d first=%0d any=%0b want %0d %0d %0b", obs_cnt, obs_first, obs_any, exp_cnt, exp_first, exp_any);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.foo = '0; bus.bar = '0;
    test_reset();
    test_scan_patterns("directed", 3, 1'b1);
    test_capture_isolation();
    test_back_to_back();
    test_mid_scan_reset();
    test_scan_patterns("random", 24, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pair_check_sequencer.md
# pair_check_sequencer

Sequenced bit-pair checker for the assertion test modules. On a start request it snapshots two `WIDTH`-bit vectors, `foo` and `bar`. It then walks an index from 0 to `COUNT-1`, one index per clock, and evaluates `foo[i] && bar[i]` for each index. It reports a per-index check strobe, a failure count and the first failing index, so that benches can bind concurrent assertions to a clocked, indexed check stream instead of a procedural loop.

## Interface
Parameters:
- `WIDTH`, 11, width of `foo`/`bar` vectors.
- `COUNT`, 10, number of indices checked (0..COUNT-1); legal range 1 ≤ COUNT ≤ WIDTH.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a scan; sampled only in IDLE.
- `foo`  input  WIDTH  first operand vector; captured on accepted start.
- `bar`  input  WIDTH  second operand vector; captured on accepted start.
- `busy`  output  1  high in SCAN and DONE.
- `chk_valid`  output  1  high during each check cycle.
- `chk_idx`  output  $clog2(WIDTH)  index under check; valid when `chk_valid` is high.
- `chk_ok`  output  1  `snap_foo[chk_idx] & snap_bar[chk_idx]`; valid when `chk_valid` is high.
- `done`  output  1  one-cycle pulse at scan completion.
- `any_fail`  output  1  at least one check failed in the last scan.
- `fail_cnt`  output  $clog2(COUNT+1)  number of failed checks in the last scan.
- `first_fail_idx`  output  $clog2(WIDTH)  lowest failing index; 0 if none.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**: on `start`=1, capture `foo`/`bar` into snapshot registers, clear `idx`, `fail_cnt`, `any_fail` and `first_fail_idx`, then go to SCAN.
- **SCAN**: `chk_valid`=1 and `chk_idx`=`idx`; `chk_ok` is combinational from the snapshot.
  - On each edge in SCAN, if `chk_ok`=0: increment `fail_cnt`. If `any_fail` was 0, load `first_fail_idx`=`idx`. Set `any_fail`=1.
  - If `idx`==COUNT-1, go to DONE; otherwise increment `idx`.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored in SCAN and DONE; it is not queued.
- Results (`any_fail`, `fail_cnt`, `first_fail_idx`) hold from DONE until the next accepted start.
- Changes on `foo`/`bar` after capture have no effect on the current scan.
- `fail_cnt` never exceeds COUNT, so no saturation logic is needed.
- Snapshot bits at index COUNT..WIDTH-1 are never checked.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and the snapshot registers reset to 0.
- Reset asserted mid-scan forces IDLE on the next edge with all outputs 0. No `done` is issued for the aborted scan.
- With start accepted at edge k:
  - `chk_valid` is high for the COUNT cycles following edges k..k+COUNT-1.
  - `done` is high in the cycle following edge k+COUNT.
  - Start to `done` latency is therefore COUNT+1 cycles.
- Back-to-back scans: the earliest next start is accepted at the edge that leaves DONE+1, i.e. `start` must be high while the FSM is in IDLE. The minimum period is COUNT+2 cycles.
- `busy` falls in the same cycle the FSM returns to IDLE.

## Configuration
- Macro `PAIR_CHECK_STOP_ON_FAIL_EN`.
- **Defined**: the first failing check ends the scan. On that edge the FSM goes to DONE, with `fail_cnt`=1, `any_fail`=1 and `first_fail_idx`=failing index. Latency is (failing index + 2) cycles from the start edge.
- **Undefined**: all COUNT indices are always checked and `fail_cnt` counts every failure.

## Test plan
- WIDTH=11, COUNT=10, `foo`=`bar`=11'h7FF, pulse `start`:
  - 10 `chk_valid` cycles with `chk_idx` 0..9, all `chk_ok`=1.
  - `done` 11 cycles after the start edge.
  - `fail_cnt`=0, `any_fail`=0.
- `foo`=11'h7FF, `bar`=11'h777 (bits 3 and 7 clear):
  - Without macro: `fail_cnt`=2, `first_fail_idx`=3, `any_fail`=1, `done` at cycle 11.
  - With macro: `done` at cycle 5, `fail_cnt`=1, `first_fail_idx`=3.
- `foo`=11'h3FF, `bar`=11'h7FF (bit 10 differs only) -> `fail_cnt`=0, because index 10 is never checked.
- Start accepted with `foo`=`bar`=11'h7FF, then `bar` driven to 0 one cycle later -> results are unaffected: `fail_cnt`=0.
- `start` held high continuously -> scans repeat every 12 cycles, and start pulses during SCAN/DONE produce no extra scans.
- `rst` asserted at the 5th `chk_valid` cycle:
  - Next cycle: all outputs 0 and no `done`.
  - A subsequent start with `bar`=11'h7FE completes with `fail_cnt`=1 and `first_fail_idx`=0.
